qspi_ctrl_master: RTL and testbench

Single-clock QSPI initiator that drives the flash / RAM A / RAM B PMOD bus from a simple request/response interface. It is the host-side counterpart of the QSPI PMOD responder: it generates the serial clock, the active-low chip selects, the command/address/mode/dummy nibble sequence and the data phase, and packs read data back into a 32-bit word. It sits between the CPU memory port and the top-level QSPI pins.

---
 rtl/qspi_ctrl_master.sv | 158 +++++++++++++++
 tb/tb_qspi_ctrl_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_ctrl_master.sv
// QSPI initiator: turns single request/response transactions into cmd/addr/mode/dummy/data
// nibble sequences on the flash / RAM A / RAM B PMOD bus, with SPI clock at clk/2.
module qspi_ctrl_master #(
    parameter int ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_dev,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [1:0]           req_len,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_error,
    output logic                 qspi_clk,
    output logic [3:0]           qspi_data_out,
    output logic [3:0]           qspi_data_oe,
    input  logic [3:0]           qspi_data_in,
    output logic                 qspi_flash_select,
    output logic                 qspi_ram_a_select,
    output logic                 qspi_ram_b_select
);

    typedef enum logic [1:0] {IDLE, SHIFT, DESEL, ERR} state_t;

    state_t                 state;
    logic [5:0]             nib_cnt;
    logic [5:0]             last_idx;
    logic                   flash_q;
    logic                   wr_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rd_shift;
    logic [31:0]            rd_next;
    logic [4:0]             rd_pos;
    logic [4:0]             first_nib;
    logic [4:0]             next_nib;
    logic                   bad_req;

    // Returns {oe, nibble} for SPI clock index idx (0-based) of a transaction.
    function automatic logic [4:0] nib_for(input logic [5:0] idx, input logic flash,
                                           input logic wr, input logic [ADDR_BITS-1:0] addr,
                                           input logic [31:0] wdata);
        logic [5:0] a;
        logic [7:0] sh;
        logic [3:0] an;
        logic [3:0] wn;
        a  = flash ? idx : idx - 6'd2;
        sh = {a, 2'b00};
        an = 4'((addr << sh) >> (ADDR_BITS - 4));
        wn = 4'(wdata >> {idx[2:1], ~idx[0], 2'b00});
        nib_for = 5'h00;
        if (flash) begin
            if (idx < 6'd6)       nib_for = {1'b1, an};
            else if (idx == 6'd6) nib_for = 5'h1A;
            else if (idx == 6'd7) nib_for = 5'h15;
        end else begin
            if (idx == 6'd0)      nib_for = 5'h10;
            else if (idx == 6'd1) nib_for = {1'b1, wr ? 4'h2 : 4'hB};
            else if (idx < 6'd8)  nib_for = {1'b1, an};
            else if (wr)          nib_for = {1'b1, wn};
        end
    endfunction

    assign bad_req = (req_dev == 2'd3) || ((req_dev == 2'd0) && req_write);

    // Read nibble j = nib_cnt-12 lands in byte j/2, high nibble first.
    assign rd_pos = {~nib_cnt[2], nib_cnt[1], ~nib_cnt[0], 2'b00};

    always_comb begin
        rd_next = rd_shift;
        rd_next[rd_pos +: 4] = qspi_data_in;
        first_nib = nib_for(6'd0, req_dev == 2'd0, req_write, req_addr, req_wdata);
        next_nib  = nib_for(nib_cnt + 6'd1, flash_q, wr_q, addr_q, wdata_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state             <= IDLE;
            req_ready         <= 1'b1;
            rsp_valid         <= 1'b0;
            rsp_error         <= 1'b0;
            rsp_rdata         <= '0;
            qspi_clk          <= 1'b0;
            qspi_data_out     <= '0;
            qspi_data_oe      <= '0;
            qspi_flash_select <= 1'b1;
            qspi_ram_a_select <= 1'b1;
            qspi_ram_b_select <= 1'b1;
            nib_cnt           <= '0;
            last_idx          <= '0;
            flash_q           <= 1'b0;
            wr_q              <= 1'b0;
            addr_q            <= '0;
            wdata_q           <= '0;
            rd_shift          <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            unique case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    if (bad_req) begin
                        state     <= ERR;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state             <= SHIFT;
                        flash_q           <= (req_dev == 2'd0);
                        wr_q              <= req_write;
                        addr_q            <= req_addr;
                        wdata_q           <= req_wdata;
                        nib_cnt           <= '0;
                        last_idx          <= (req_write ? 6'd9 : 6'd13) + {3'b000, req_len, 1'b0};
                        rd_shift          <= '0;
                        qspi_clk          <= 1'b0;
                        qspi_flash_select <= (req_dev != 2'd0);
                        qspi_ram_a_select <= (req_dev != 2'd1);
                        qspi_ram_b_select <= (req_dev != 2'd2);
                        qspi_data_oe      <= {4{first_nib[4]}};
                        qspi_data_out     <= first_nib[3:0];
                    end
                end
                SHIFT: if (!qspi_clk) begin
                    qspi_clk <= 1'b1;
                end else begin
                    if (!wr_q && nib_cnt >= 6'd12) rd_shift <= rd_next;
                    if (nib_cnt == last_idx) begin
                        state             <= DESEL;
                        qspi_clk          <= 1'b0;
                        qspi_flash_select <= 1'b1;
                        qspi_ram_a_select <= 1'b1;
                        qspi_ram_b_select <= 1'b1;
                        qspi_data_oe      <= '0;
                        qspi_data_out     <= '0;
                        rsp_valid         <= 1'b1;
                        rsp_rdata         <= wr_q ? '0 : rd_next;
                    end else begin
                        nib_cnt       <= nib_cnt + 6'd1;
                        qspi_clk      <= 1'b0;
                        qspi_data_oe  <= {4{next_nib[4]}};
                        qspi_data_out <= next_nib[3:0];
                    end
                end
                DESEL, ERR: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_ctrl_master.sv
// Scoreboard bench for qspi_ctrl_master with a behavioural PMOD responder (flash ROM, RAM A, RAM B).
module tb_qspi_ctrl_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_dev = '0;
    logic        req_write = 1'b0;
    logic [23:0] req_addr = '0;
    logic [1:0]  req_len = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        qspi_clk;
    logic [3:0]  qspi_data_out;
    logic [3:0]  qspi_data_oe;
    logic [3:0]  qspi_data_in = '0;
    logic        qspi_flash_select;
    logic        qspi_ram_a_select;
    logic        qspi_ram_b_select;

    qspi_ctrl_master #(.ADDR_BITS(24)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_dev(req_dev),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .qspi_clk(qspi_clk), .qspi_data_out(qspi_data_out), .qspi_data_oe(qspi_data_oe),
        .qspi_data_in(qspi_data_in), .qspi_flash_select(qspi_flash_select),
        .qspi_ram_a_select(qspi_ram_a_select), .qspi_ram_b_select(qspi_ram_b_select)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    int         acc_q[$];
    logic [4:0] bus_q[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_note(input string name);
        checks++;
        $display("FAIL %s: wait bound expired, got no event expected one", name);
    endtask

    always @(posedge clk) begin
        if (rstn && req_valid && req_ready) acc_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    // Responder model and bus observation
    logic [7:0]  flash_mem [0:4095];
    logic [7:0]  rama_mem  [0:4095];
    logic [7:0]  ramb_mem  [0:4095];
    int          k = 0;
    logic        prev_clk = 1'b0;
    logic [2:0]  prev_sel = 3'b111;
    logic [23:0] r_addr = '0;
    logic [7:0]  r_cmd = '0;
    logic [3:0]  hi_nib = '0;
    int          clk_rises = 0, fl_falls = 0, ra_falls = 0, rb_falls = 0;
    int          hi_run = 0, last_gap = 0;
    logic        overlap = 1'b0;

    function automatic logic [7:0] mem_rd(input logic [1:0] d, input logic [11:0] a);
        case (d)
            2'd0:    mem_rd = flash_mem[a];
            2'd1:    mem_rd = rama_mem[a];
            default: mem_rd = ramb_mem[a];
        endcase
    endfunction

    always @(negedge clk) begin
        logic [2:0]  sel;
        logic [1:0]  d;
        logic [4:0]  e;
        logic [7:0]  b;
        int          j;
        sel = {qspi_ram_b_select, qspi_ram_a_select, qspi_flash_select};
        if (prev_sel[0] && !sel[0]) fl_falls++;
        if (prev_sel[1] && !sel[1]) ra_falls++;
        if (prev_sel[2] && !sel[2]) rb_falls++;
        if ($countones(~sel) > 1) overlap = 1'b1;
        d = !sel[0] ? 2'd0 : (!sel[1] ? 2'd1 : 2'd2);
        if (&sel) begin
            hi_run++;
            k = 0;
        end else if (hi_run > 0) begin
            last_gap = hi_run;
            hi_run = 0;
        end
        if (qspi_clk && !prev_clk) begin
            clk_rises++;
            if (!(&sel)) begin
                k++;
                if (bus_q.size() > 0) begin
                    e = bus_q.pop_front();
                    if (e[4]) chk("bus_nib", {24'h0, qspi_data_oe, qspi_data_out}, {24'h0, 4'hF, e[3:0]});
                    else      chk("bus_oe_off", {28'h0, qspi_data_oe}, 32'h0);
                end
                if (d == 2'd0) begin
                    if (k <= 6) r_addr = {r_addr[19:0], qspi_data_out};
                end else if (k <= 2) begin
                    r_cmd = {r_cmd[3:0], qspi_data_out};
                end else if (k <= 8) begin
                    r_addr = {r_addr[19:0], qspi_data_out};
                end else if (r_cmd == 8'h02) begin
                    j = k - 9;
                    if (j % 2 == 0) hi_nib = qspi_data_out;
                    else if (d == 2'd1) rama_mem[12'(r_addr + 24'(j / 2))] = {hi_nib, qspi_data_out};
                    else ramb_mem[12'(r_addr + 24'(j / 2))] = {hi_nib, qspi_data_out};
                end
                if (k >= 13 && (d == 2'd0 || r_cmd == 8'h0B)) begin
                    j = k - 13;
                    b = mem_rd(d, 12'(r_addr + 24'(j / 2)));
                    qspi_data_in = (j % 2 == 0) ? b[7:4] : b[3:0];
                end
            end
        end
        prev_clk = qspi_clk;
        prev_sel = sel;
    end

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (rstn && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
            end else begin
                e = sb.pop_front();
                a = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
                chk("rsp_error", {31'h0, rsp_error}, {31'h0, e.err});
                if (e.chk_data) chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_latency", cyc - a, e.lat);
            end
        end
    end

    task automatic issue(input logic [1:0] dev, input logic wr, input logic [23:0] addr,
                         input logic [1:0] len, input logic [31:0] wd, input bit keep,
                         output int acc);
        int n = 0;
        req_dev = dev; req_write = wr; req_addr = addr; req_len = len; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        while (!req_ready && n < 500) begin
            @(posedge clk);
            n++;
        end
        acc = cyc;
        if (n >= 500) fail_note("accept_wait");
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_note("rsp_wait");
    endtask

    initial begin
        int a1, a2, f0, f1, f2, cr;
        int n;
        logic [4:0] fl_seq [20];
        logic [4:0] wr_seq [12];
        fl_seq = '{5'h10, 5'h10, 5'h10, 5'h10, 5'h11, 5'h10, 5'h1A, 5'h15,
                   5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00,
                   5'h00, 5'h00, 5'h00, 5'h00};
        wr_seq = '{5'h10, 5'h12, 5'h10, 5'h10, 5'h10, 5'h11, 5'h10, 5'h10,
                   5'h1E, 5'h1F, 5'h1B, 5'h1E};
        for (int unsigned i = 0; i < 4096; i++) begin
            flash_mem[i] = 8'h00;
            rama_mem[i]  = 8'h00;
            ramb_mem[i]  = 8'h00;
        end
        flash_mem[16] = 8'h11; flash_mem[17] = 8'h22;
        flash_mem[18] = 8'h33; flash_mem[19] = 8'h44;
        ramb_mem[256] = 8'hC3;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_error", {31'h0, rsp_error}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_selects", {29'h0, qspi_ram_b_select, qspi_ram_a_select, qspi_flash_select}, 32'h7);
        chk("rst_qspi_clk", {31'h0, qspi_clk}, 32'h0);
        chk("rst_data_out", {28'h0, qspi_data_out}, 32'h0);
        chk("rst_data_oe", {28'h0, qspi_data_oe}, 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // Flash read, 4 bytes
        foreach (fl_seq[i]) bus_q.push_back(fl_seq[i]);
        sb.push_back('{32'h44332211, 1'b0, 1'b1, 41});
        issue(2'd0, 1'b0, 24'h000010, 2'd3, 32'h0, 1'b0, a1);
        wait_done();
        chk("bus_seq_consumed", bus_q.size(), 32'h0);

        // RAM A write 2 bytes, then read back
        foreach (wr_seq[i]) bus_q.push_back(wr_seq[i]);
        sb.push_back('{32'h0, 1'b0, 1'b0, 25});
        issue(2'd1, 1'b1, 24'h000100, 2'd1, 32'h0000BEEF, 1'b0, a1);
        wait_done();
        sb.push_back('{32'h0000BEEF, 1'b0, 1'b1, 33});
        issue(2'd1, 1'b0, 24'h000100, 2'd1, 32'h0, 1'b0, a1);
        wait_done();

        // RAM B read of same address: only RAM B select moves
        f0 = fl_falls; f1 = ra_falls; f2 = rb_falls;
        sb.push_back('{32'h000000C3, 1'b0, 1'b1, 29});
        issue(2'd2, 1'b0, 24'h000100, 2'd0, 32'h0, 1'b0, a1);
        wait_done();
        chk("ramb_flash_sel_quiet", fl_falls - f0, 32'd0);
        chk("ramb_rama_sel_quiet", ra_falls - f1, 32'd0);
        chk("ramb_sel_once", rb_falls - f2, 32'd1);

        // Rejected requests back to back: flash write then dev 3
        f0 = fl_falls + ra_falls + rb_falls; cr = clk_rises;
        sb.push_back('{32'h0, 1'b1, 1'b0, 1});
        sb.push_back('{32'h0, 1'b1, 1'b0, 1});
        issue(2'd0, 1'b1, 24'h000020, 2'd0, 32'h12345678, 1'b1, a1);
        issue(2'd3, 1'b0, 24'h000020, 2'd0, 32'h0, 1'b0, a2);
        wait_done();
        chk("err_accept_gap", a2 - a1, 32'd2);
        chk("err_no_select", fl_falls + ra_falls + rb_falls - f0, 32'd0);
        chk("err_no_spi_clk", clk_rises - cr, 32'd0);

        // Back-to-back flash reads with req_valid held
        sb.push_back('{32'h00000011, 1'b0, 1'b1, 29});
        sb.push_back('{32'h00004433, 1'b0, 1'b1, 33});
        issue(2'd0, 1'b0, 24'h000010, 2'd0, 32'h0, 1'b1, a1);
        issue(2'd0, 1'b0, 24'h000012, 2'd1, 32'h0, 1'b0, a2);
        wait_done();
        chk("b2b_accept_gap", a2 - a1, 32'd30);
        chk("b2b_cs_high_cycles", last_gap, 32'd2);

        // Reset at SPI clock 7 of a flash read
        issue(2'd0, 1'b0, 24'h000010, 2'd3, 32'h0, 1'b0, a1);
        n = 0;
        while (k != 7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_note("spi_clk7_wait");
        rstn = 1'b0;
        #1;
        chk("abort_selects", {29'h0, qspi_ram_b_select, qspi_ram_a_select, qspi_flash_select}, 32'h7);
        chk("abort_data_oe", {28'h0, qspi_data_oe}, 32'h0);
        chk("abort_qspi_clk", {31'h0, qspi_clk}, 32'h0);
        chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
        acc_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        sb.push_back('{32'h00004433, 1'b0, 1'b1, 33});
        issue(2'd0, 1'b0, 24'h000012, 2'd1, 32'h0, 1'b0, a1);
        wait_done();

        repeat (4) @(negedge clk);
        chk("single_select_low", {31'h0, overlap}, 32'h0);
        chk("scoreboard_drained", sb.size(), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
